// File: rtl/axi_prot_chk.sv
// axi_prot_chk: passive AXI protocol checker for one master/slave link.
// It snoops all five channels and flags handshake-stability and
// burst-framing violations. It drives no AXI signal.
//
// Ports:
//   i_aclk, i_areset          clock, synchronous active-high reset
//   i_aw*, i_w*, i_b*         write address / data / response channels
//   i_ar*, i_r*               read address / data channels
//   i_err_clr                 clears o_err_sticky, o_err_first, o_err_count
//   o_err_pulse[11:0]         one-cycle flag per error code
//   o_err_sticky[11:0]        accumulated flags
//   o_err_first[3:0]          lowest code of the first error since reset/clear
//   o_err_count[15:0]         saturating count of cycles with any error
//   o_wr/rd_outstanding       tracked AW / AR bursts
//
// Error codes: 0 AW stable, 1 W stable, 2 AR stable, 3 B stable, 4 R stable,
//   5 WLAST early, 6 WLAST missing, 7 W without AW, 8 unexpected B,
//   9 unexpected R, 10 RLAST wrong, 11 tracking FIFO overflow.
module axi_prot_chk #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int LEN_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               i_aclk,
  input  logic                               i_areset,
  input  logic [ID_WIDTH-1:0]                i_awid,
  input  logic [ADDR_WIDTH-1:0]              i_awaddr,
  input  logic [LEN_WIDTH-1:0]               i_awlen,
  input  logic [2:0]                         i_awsize,
  input  logic [1:0]                         i_awburst,
  input  logic                               i_awvalid,
  input  logic                               i_awready,
  input  logic [DATA_WIDTH-1:0]              i_wdata,
  input  logic [DATA_WIDTH/8-1:0]            i_wstrb,
  input  logic                               i_wlast,
  input  logic                               i_wvalid,
  input  logic                               i_wready,
  input  logic [ID_WIDTH-1:0]                i_bid,
  input  logic [1:0]                         i_bresp,
  input  logic                               i_bvalid,
  input  logic                               i_bready,
  input  logic [ID_WIDTH-1:0]                i_arid,
  input  logic [ADDR_WIDTH-1:0]              i_araddr,
  input  logic [LEN_WIDTH-1:0]               i_arlen,
  input  logic [2:0]                         i_arsize,
  input  logic [1:0]                         i_arburst,
  input  logic                               i_arvalid,
  input  logic                               i_arready,
  input  logic [ID_WIDTH-1:0]                i_rid,
  input  logic [DATA_WIDTH-1:0]              i_rdata,
  input  logic [1:0]                         i_rresp,
  input  logic                               i_rlast,
  input  logic                               i_rvalid,
  input  logic                               i_rready,
  input  logic                               i_err_clr,
  output logic [11:0]                        o_err_pulse,
  output logic [11:0]                        o_err_sticky,
  output logic [3:0]                         o_err_first,
  output logic [15:0]                        o_err_count,
  output logic [$clog2(MAX_OUTSTANDING):0]   o_wr_outstanding,
  output logic [$clog2(MAX_OUTSTANDING):0]   o_rd_outstanding
);

  localparam int PW    = $clog2(MAX_OUTSTANDING);
  localparam int CW    = PW + 1;
  localparam int BPW   = 8;
  localparam int AXW   = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 5;
  localparam int WW    = DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int BW    = ID_WIDTH + 2;
  localparam int RW    = ID_WIDTH + DATA_WIDTH + 3;
  localparam logic [CW-1:0] FULL = CW'(MAX_OUTSTANDING);

  // stall registers: VALID && !READY plus the payload seen at that edge
  logic           r_aw_stall, r_w_stall, r_ar_stall, r_b_stall, r_r_stall;
  logic [AXW-1:0] r_aw_pl, r_ar_pl;
  logic [WW-1:0]  r_w_pl;
  logic [BW-1:0]  r_b_pl;
  logic [RW-1:0]  r_r_pl;

  logic [LEN_WIDTH-1:0] r_wr_len [MAX_OUTSTANDING];
  logic [PW-1:0]        r_wr_wptr, r_wr_rptr;
  logic [CW-1:0]        r_wr_cnt;
  logic [LEN_WIDTH-1:0] r_wbeat;
  logic [BPW-1:0]       r_b_pending;

  logic [ID_WIDTH-1:0]  r_rd_id  [MAX_OUTSTANDING];
  logic [LEN_WIDTH-1:0] r_rd_len [MAX_OUTSTANDING];
  logic [PW-1:0]        r_rd_wptr, r_rd_rptr;
  logic [CW-1:0]        r_rd_cnt;
  logic [LEN_WIDTH-1:0] r_rbeat;

  logic [11:0] r_err_pulse, r_err_sticky;
  logic [3:0]  r_err_first;
  logic [15:0] r_err_count;

  logic [AXW-1:0] w_aw_pl, w_ar_pl;
  logic [WW-1:0]  w_w_pl;
  logic [BW-1:0]  w_b_pl;
  logic [RW-1:0]  w_r_pl;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_wr_full, w_rd_full, w_w_at_last, w_r_at_last;
  logic w_aw_push, w_ar_push, w_wpop, w_wbeat_inc, w_rpop, w_rbeat_inc, w_b_dec;
  logic [11:0] w_err;
  logic [3:0]  w_first;

  always_comb begin
    w_aw_pl = {i_awid, i_awaddr, i_awlen, i_awsize, i_awburst};
    w_ar_pl = {i_arid, i_araddr, i_arlen, i_arsize, i_arburst};
    w_w_pl  = {i_wdata, i_wstrb, i_wlast};
    w_b_pl  = {i_bid, i_bresp};
    w_r_pl  = {i_rid, i_rdata, i_rresp, i_rlast};
    w_aw_hs = i_awvalid & i_awready;
    w_w_hs  = i_wvalid & i_wready;
    w_b_hs  = i_bvalid & i_bready;
    w_ar_hs = i_arvalid & i_arready;
    w_r_hs  = i_rvalid & i_rready;
    w_wr_full   = (r_wr_cnt == FULL);
    w_rd_full   = (r_rd_cnt == FULL);
    w_w_at_last = (r_wbeat == r_wr_len[r_wr_rptr]);
    w_r_at_last = (r_rbeat == r_rd_len[r_rd_rptr]);
    w_err       = '0;
    w_wpop      = 1'b0;
    w_wbeat_inc = 1'b0;
    w_rpop      = 1'b0;
    w_rbeat_inc = 1'b0;
    w_b_dec     = 1'b0;

    w_err[0] = r_aw_stall && (!i_awvalid || (w_aw_pl != r_aw_pl));
    w_err[1] = r_w_stall  && (!i_wvalid  || (w_w_pl  != r_w_pl));
    w_err[2] = r_ar_stall && (!i_arvalid || (w_ar_pl != r_ar_pl));
    w_err[3] = r_b_stall  && (!i_bvalid  || (w_b_pl  != r_b_pl));
    w_err[4] = r_r_stall  && (!i_rvalid  || (w_r_pl  != r_r_pl));

    if (w_w_hs) begin
      if (r_wr_cnt == '0) begin
        w_err[7] = 1'b1;
      end else begin
        w_err[5] = i_wlast && !w_w_at_last;
        w_err[6] = w_w_at_last && !i_wlast;
        // either end marker closes the head burst so later bursts resync
        if (i_wlast || w_w_at_last) w_wpop = 1'b1;
        else                        w_wbeat_inc = 1'b1;
      end
    end

    // a burst completing this cycle can already be answered by B
    if (w_b_hs) begin
      if ((r_b_pending == '0) && !w_wpop) w_err[8] = 1'b1;
      else                                w_b_dec = 1'b1;
    end

    if (w_r_hs) begin
      if ((r_rd_cnt == '0) || (i_rid != r_rd_id[r_rd_rptr])) begin
        w_err[9] = 1'b1;
      end else begin
        w_err[10] = (i_rlast != w_r_at_last);
        if (i_rlast || w_r_at_last) w_rpop = 1'b1;
        else                        w_rbeat_inc = 1'b1;
      end
    end

    w_aw_push = w_aw_hs && !w_wr_full;
    w_ar_push = w_ar_hs && !w_rd_full;
    w_err[11] = (w_aw_hs && w_wr_full) || (w_ar_hs && w_rd_full);

    w_first = '0;
    for (int i = 11; i >= 0; i--) begin
      if (w_err[i]) w_first = 4'(i);
    end
  end

  // FIFO storage needs no reset; pointers and counts define validity
  always_ff @(posedge i_aclk) begin
    if (w_aw_push) r_wr_len[r_wr_wptr] <= i_awlen;
    if (w_ar_push) begin
      r_rd_id[r_rd_wptr]  <= i_arid;
      r_rd_len[r_rd_wptr] <= i_arlen;
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_aw_stall   <= 1'b0;
      r_w_stall    <= 1'b0;
      r_ar_stall   <= 1'b0;
      r_b_stall    <= 1'b0;
      r_r_stall    <= 1'b0;
      r_aw_pl      <= '0;
      r_w_pl       <= '0;
      r_ar_pl      <= '0;
      r_b_pl       <= '0;
      r_r_pl       <= '0;
      r_wr_wptr    <= '0;
      r_wr_rptr    <= '0;
      r_wr_cnt     <= '0;
      r_wbeat      <= '0;
      r_b_pending  <= '0;
      r_rd_wptr    <= '0;
      r_rd_rptr    <= '0;
      r_rd_cnt     <= '0;
      r_rbeat      <= '0;
      r_err_pulse  <= '0;
      r_err_sticky <= '0;
      r_err_first  <= '0;
      r_err_count  <= '0;
    end else begin
      r_aw_stall <= i_awvalid && !i_awready;
      r_w_stall  <= i_wvalid  && !i_wready;
      r_ar_stall <= i_arvalid && !i_arready;
      r_b_stall  <= i_bvalid  && !i_bready;
      r_r_stall  <= i_rvalid  && !i_rready;
      r_aw_pl    <= w_aw_pl;
      r_w_pl     <= w_w_pl;
      r_ar_pl    <= w_ar_pl;
      r_b_pl     <= w_b_pl;
      r_r_pl     <= w_r_pl;

      if (w_aw_push) r_wr_wptr <= r_wr_wptr + PW'(1);
      if (w_wpop)    r_wr_rptr <= r_wr_rptr + PW'(1);
      case ({w_aw_push, w_wpop})
        2'b10:   r_wr_cnt <= r_wr_cnt + CW'(1);
        2'b01:   r_wr_cnt <= r_wr_cnt - CW'(1);
        default: r_wr_cnt <= r_wr_cnt;
      endcase
      if (w_wpop)           r_wbeat <= '0;
      else if (w_wbeat_inc) r_wbeat <= r_wbeat + LEN_WIDTH'(1);
      case ({w_wpop, w_b_dec})
        2'b10:   if (r_b_pending != '1) r_b_pending <= r_b_pending + BPW'(1);
        2'b01:   r_b_pending <= r_b_pending - BPW'(1);
        default: r_b_pending <= r_b_pending;
      endcase

      if (w_ar_push) r_rd_wptr <= r_rd_wptr + PW'(1);
      if (w_rpop)    r_rd_rptr <= r_rd_rptr + PW'(1);
      case ({w_ar_push, w_rpop})
        2'b10:   r_rd_cnt <= r_rd_cnt + CW'(1);
        2'b01:   r_rd_cnt <= r_rd_cnt - CW'(1);
        default: r_rd_cnt <= r_rd_cnt;
      endcase
      if (w_rpop)           r_rbeat <= '0;
      else if (w_rbeat_inc) r_rbeat <= r_rbeat + LEN_WIDTH'(1);

      r_err_pulse <= w_err;
      if (i_err_clr) begin
        r_err_sticky <= '0;
        r_err_first  <= '0;
        r_err_count  <= '0;
      end else begin
        r_err_sticky <= r_err_sticky | w_err;
        if ((r_err_sticky == '0) && (w_err != '0)) r_err_first <= w_first;
        if ((w_err != '0) && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign o_err_pulse      = r_err_pulse;
  assign o_err_sticky     = r_err_sticky;
  assign o_err_first      = r_err_first;
  assign o_err_count      = r_err_count;
  assign o_wr_outstanding = r_wr_cnt;
  assign o_rd_outstanding = r_rd_cnt;

endmodule

// File: tb/tb_axi_prot_chk.sv
module tb_axi_prot_chk;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int LW = 4;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic [IW-1:0] awid = '0, bid = '0, arid = '0, rid = '0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [LW-1:0] awlen = '0, arlen = '0;
  logic [2:0]    awsize = 3'd2, arsize = 3'd2;
  logic [1:0]    awburst = 2'b01, arburst = 2'b01, bresp = '0, rresp = '0;
  logic          awvalid = 0, awready = 0, wvalid = 0, wready = 0, wlast = 0;
  logic          bvalid = 0, bready = 0, arvalid = 0, arready = 0;
  logic          rvalid = 0, rready = 0, rlast = 0, err_clr = 0;
  logic [DW-1:0] wdata = '0, rdata = '0;
  logic [DW/8-1:0] wstrb = '1;
  logic [11:0]   err_pulse, err_sticky;
  logic [3:0]    err_first;
  logic [15:0]   err_count;
  logic [2:0]    wr_out, rd_out;

  always #5 clk = ~clk;

  axi_prot_chk #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
                 .LEN_WIDTH(LW), .MAX_OUTSTANDING(MO)) dut (
    .i_aclk(clk), .i_areset(areset),
    .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize),
    .i_awburst(awburst), .i_awvalid(awvalid), .i_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid),
    .i_wready(wready),
    .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .i_bready(bready),
    .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize),
    .i_arburst(arburst), .i_arvalid(arvalid), .i_arready(arready),
    .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast),
    .i_rvalid(rvalid), .i_rready(rready),
    .i_err_clr(err_clr),
    .o_err_pulse(err_pulse), .o_err_sticky(err_sticky), .o_err_first(err_first),
    .o_err_count(err_count), .o_wr_outstanding(wr_out), .o_rd_outstanding(rd_out)
  );

  typedef struct {
    logic [11:0] pulse;
    logic [11:0] sticky;
    logic [3:0]  first;
    logic [15:0] count;
    logic [2:0]  wr;
    logic [2:0]  rd;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   e_wr = 0, e_rd = 0;
  logic [11:0] m_sticky = '0;
  logic [3:0]  m_first = '0;
  logic [15:0] m_count = '0;

  task automatic chk(input string name, input string fld, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0h expected %0h", name, fld, got, exp);
    end
  endtask

  // monitor: every edge presents one set of outputs; compare against the queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk(mon_e.name, "pulse",  {20'd0, err_pulse},  {20'd0, mon_e.pulse});
        chk(mon_e.name, "sticky", {20'd0, err_sticky}, {20'd0, mon_e.sticky});
        chk(mon_e.name, "first",  {28'd0, err_first},  {28'd0, mon_e.first});
        chk(mon_e.name, "count",  {16'd0, err_count},  {16'd0, mon_e.count});
        chk(mon_e.name, "wr_out", {29'd0, wr_out},     {29'd0, mon_e.wr});
        chk(mon_e.name, "rd_out", {29'd0, rd_out},     {29'd0, mon_e.rd});
      end
    end
  end

  // one clock edge with the inputs currently driven; p is the hand-computed error pulse
  task automatic cyc(input logic [11:0] p, input string name);
    exp_t e;
    logic [3:0] f;
    @(posedge clk);
    f = '0;
    for (int i = 11; i >= 0; i--) if (p[i]) f = 4'(i);
    if (areset) begin
      m_sticky = '0; m_first = '0; m_count = '0;
      e.pulse = '0;
    end else begin
      e.pulse = p;
      if (err_clr) begin
        m_sticky = '0; m_first = '0; m_count = '0;
      end else begin
        if (m_sticky == '0 && p != '0) m_first = f;
        m_sticky = m_sticky | p;
        if (p != '0 && m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end
    end
    e.sticky = m_sticky;
    e.first  = m_first;
    e.count  = m_count;
    e.wr     = 3'(e_wr);
    e.rd     = 3'(e_rd);
    e.name   = name;
    q.push_back(e);
    #1;
  endtask

  task automatic idle();
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
    bvalid = 0; bready = 0; arvalid = 0; arready = 0;
    rvalid = 0; rready = 0; rlast = 0; err_clr = 0;
  endtask

  task automatic clear();
    idle(); err_clr = 1; cyc(12'h000, "clr"); err_clr = 0;
  endtask

  initial begin
    // reset
    cyc(12'h000, "reset0");
    cyc(12'h000, "reset1");
    areset = 0;
    cyc(12'h000, "idle");

    // clean write burst LEN=3
    awvalid = 1; awready = 1; awlen = 4'd3; awaddr = 32'h40; e_wr = 1;
    cyc(12'h000, "aw_len3");
    idle(); wvalid = 1; wready = 1;
    for (int b = 0; b < 4; b++) begin
      wdata = 32'hA000 + b; wlast = (b == 3);
      if (b == 3) e_wr = 0;
      cyc(12'h000, "w_beat");
    end
    idle(); bvalid = 1; bready = 1;
    cyc(12'h000, "b_ok");
    cyc(12'h100, "b_extra");
    clear();

    // AW payload change while stalled
    idle(); awvalid = 1; awready = 0; awaddr = 32'h100; awlen = 4'd0;
    cyc(12'h000, "aw_stall");
    awaddr = 32'h104;
    cyc(12'h001, "aw_chg");
    awready = 1; e_wr = 1;
    cyc(12'h000, "aw_hs");
    idle();
    cyc(12'h000, "aw_after");
    wvalid = 1; wready = 1; wlast = 1; e_wr = 0;
    cyc(12'h000, "w_single");
    idle(); bvalid = 1; bready = 1;
    cyc(12'h000, "b_single");
    clear();

    // WLAST early, then a clean LEN=0 burst
    awvalid = 1; awready = 1; awlen = 4'd3; e_wr = 1;
    cyc(12'h000, "aw_early");
    idle(); wvalid = 1; wready = 1;
    cyc(12'h000, "w_e0");
    wlast = 1; e_wr = 0;
    cyc(12'h020, "wlast_early");
    idle(); bvalid = 1; bready = 1;
    cyc(12'h000, "b_early");
    idle(); awvalid = 1; awready = 1; awlen = 4'd0; e_wr = 1;
    cyc(12'h000, "aw_len0");
    idle(); wvalid = 1; wready = 1; wlast = 1; e_wr = 0;
    cyc(12'h000, "w_len0");
    idle(); bvalid = 1; bready = 1;
    cyc(12'h000, "b_len0");

    // WLAST missing on LEN=1
    idle(); awvalid = 1; awready = 1; awlen = 4'd1; e_wr = 1;
    cyc(12'h000, "aw_miss");
    idle(); wvalid = 1; wready = 1;
    cyc(12'h000, "w_m0");
    e_wr = 0;
    cyc(12'h040, "wlast_missing");
    idle(); bvalid = 1; bready = 1;
    cyc(12'h000, "b_miss");

    // W without AW, B without write
    idle(); wvalid = 1; wready = 1; wlast = 1;
    cyc(12'h080, "w_no_aw");
    idle(); bvalid = 1; bready = 1;
    cyc(12'h100, "b_unexp");

    // B dropped while stalled
    idle(); bvalid = 1; bid = 4'd1;
    cyc(12'h000, "b_stall");
    bvalid = 0;
    cyc(12'h008, "b_drop");

    // reads in order, ID mismatch and RLAST early
    idle(); arvalid = 1; arready = 1; arid = 4'd1; arlen = 4'd1; e_rd = 1;
    cyc(12'h000, "ar_id1");
    arid = 4'd2; e_rd = 2;
    cyc(12'h000, "ar_id2");
    idle(); rvalid = 1; rready = 1; rid = 4'd2;
    cyc(12'h200, "rid_order");
    rid = 4'd1; rlast = 1; e_rd = 1;
    cyc(12'h400, "rlast_early");
    rid = 4'd2; rlast = 0;
    cyc(12'h000, "r2_b0");
    rlast = 1; e_rd = 0;
    cyc(12'h000, "r2_b1");
    cyc(12'h200, "r_empty");

    // RLAST missing on LEN=0
    idle(); arvalid = 1; arready = 1; arid = 4'd3; arlen = 4'd0; e_rd = 1;
    cyc(12'h000, "ar_id3");
    idle(); rvalid = 1; rready = 1; rid = 4'd3; rlast = 0; e_rd = 0;
    cyc(12'h400, "rlast_missing");

    // same-cycle push and pop on the read FIFO
    idle(); arvalid = 1; arready = 1; arid = 4'd4; arlen = 4'd0; e_rd = 1;
    cyc(12'h000, "ar_id4");
    arid = 4'd5; rvalid = 1; rready = 1; rid = 4'd4; rlast = 1;
    cyc(12'h000, "push_pop");
    arvalid = 0; arready = 0; rid = 4'd5; e_rd = 0;
    cyc(12'h000, "r_id5");

    // R payload change and drop while stalled
    idle(); rvalid = 1; rid = 4'd6; rdata = 32'h1111;
    cyc(12'h000, "r_stall");
    rdata = 32'h2222;
    cyc(12'h010, "r_chg");
    rvalid = 0;
    cyc(12'h010, "r_drop");
    cyc(12'h000, "r_quiet");

    // write FIFO overflow, then reset clears everything
    idle(); awvalid = 1; awready = 1; awlen = 4'd0;
    for (int k = 1; k <= 4; k++) begin
      e_wr = k;
      cyc(12'h000, "aw_fill");
    end
    cyc(12'h800, "overflow");
    idle(); areset = 1; e_wr = 0; e_rd = 0;
    cyc(12'h000, "reset_mid");
    areset = 0;
    wvalid = 1; wready = 1; wlast = 1;
    cyc(12'h080, "w_after_reset");

    // multi-bit first error takes the lowest code
    clear();
    wvalid = 1; wready = 1; wlast = 1; bvalid = 1; bready = 1;
    cyc(12'h180, "multi_err");

    // error and clear in the same cycle
    clear();
    bvalid = 1; bready = 1; err_clr = 1;
    cyc(12'h100, "err_with_clr");
    idle();
    cyc(12'h000, "after_clr");

    // saturate the error counter
    bvalid = 1; bready = 1;
    for (int k = 0; k < 70000; k++) cyc(12'h100, "sat");
    idle();
    cyc(12'h000, "sat_end");
    clear();

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #2;
    if (q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
